sprite_rom_arbiter: RTL and testbench

- Shares one single-port sprite ROM between the two player render paths (player 0 and player 1).
- Runs on the 50 MHz clock, so two ROM lookups fit in each 25 MHz pixel period.
- Grants one request per cycle using round-robin priority and tracks in-flight reads through the fixed ROM latency.
- Returns each read to the requester that issued it; also keeps per-frame stall statistics for on-board debug on HEX/LEDR.

---
 rtl/sprite_rom_arbiter.sv | 144 ++++++++++++++
 tb/tb_sprite_rom_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one single-port sprite ROM between two player render paths.
// Tracks in-flight reads through the fixed ROM latency and keeps per-frame stall counters.
module sprite_rom_arbiter #(
    parameter int ADDR_W  = 17,
    parameter int DATA_W  = 8,
    parameter int ROM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              frame_start,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              rsp_valid0,
    output logic              rsp_valid1,
    output logic [DATA_W-1:0] rsp_data,
    output logic [7:0]        stall0,
    output logic [7:0]        stall1
);

    if (ROM_LAT < 1 || ROM_LAT > 4) begin : g_bad_lat
        $error("sprite_rom_arbiter: ROM_LAT must be in 1..4");
    end

    logic              r_last;
    logic [ROM_LAT-1:0] r_tag_vld;
    logic [ROM_LAT-1:0] r_tag_id;
    logic              r_rsp_valid0;
    logic              r_rsp_valid1;
    logic [DATA_W-1:0] r_rsp_data;
    logic [7:0]        r_stall0;
    logic [7:0]        r_stall1;

    logic              w_last_eff;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_rom_en;
    logic              w_out_vld;
    logic              w_out_id;

    // Handshake: reqN/addrN are held until gntN is seen high in the same cycle;
    // the requester may drop or change them only in the following cycle.
    // A frame start forces player 0 to win any conflict in that cycle.
    always_comb begin
        w_last_eff = frame_start | r_last;
        w_gnt0     = 1'b0;
        w_gnt1     = 1'b0;
        if (rst && enable) begin
            if (req0 && req1) begin
                if (w_last_eff) begin
                    w_gnt0 = 1'b1;
                end else begin
                    w_gnt1 = 1'b1;
                end
            end else if (req0) begin
                w_gnt0 = 1'b1;
            end else if (req1) begin
                w_gnt1 = 1'b1;
            end
        end
    end

    assign w_rom_en  = w_gnt0 | w_gnt1;
    assign w_out_vld = r_tag_vld[ROM_LAT-1];
    assign w_out_id  = r_tag_id[ROM_LAT-1];

    assign gnt0     = w_gnt0;
    assign gnt1     = w_gnt1;
    assign rom_en   = w_rom_en;
    assign rom_addr = !rst ? '0 : (w_gnt1 ? addr1 : addr0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last <= 1'b1;
        end else if (w_gnt0) begin
            r_last <= 1'b0;
        end else if (w_gnt1) begin
            r_last <= 1'b1;
        end else if (frame_start) begin
            r_last <= 1'b1;
        end
    end

    // Tag pipeline shifts every cycle, independent of enable, so issued reads always drain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tag_vld <= '0;
            r_tag_id  <= '0;
        end else begin
            r_tag_vld[0] <= w_rom_en;
            r_tag_id[0]  <= w_gnt1;
            for (int i = 1; i < ROM_LAT; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag_id[i]  <= r_tag_id[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rsp_valid0 <= 1'b0;
            r_rsp_valid1 <= 1'b0;
            r_rsp_data   <= '0;
        end else begin
            r_rsp_valid0 <= w_out_vld & ~w_out_id;
            r_rsp_valid1 <= w_out_vld & w_out_id;
            if (w_out_vld) begin
                r_rsp_data <= rom_data;
            end
        end
    end

    // Frame start clears both counters and wins over a same-cycle denial.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall0 <= 8'd0;
            r_stall1 <= 8'd0;
        end else if (frame_start) begin
            r_stall0 <= 8'd0;
            r_stall1 <= 8'd0;
        end else begin
            if (req0 && !w_gnt0 && (r_stall0 != 8'hFF)) begin
                r_stall0 <= r_stall0 + 8'd1;
            end
            if (req1 && !w_gnt1 && (r_stall1 != 8'hFF)) begin
                r_stall1 <= r_stall1 + 8'd1;
            end
        end
    end

    assign rsp_valid0 = r_rsp_valid0;
    assign rsp_valid1 = r_rsp_valid1;
    assign rsp_data   = r_rsp_data;
    assign stall0     = r_stall0;
    assign stall1     = r_stall1;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed table-driven bench for sprite_rom_arbiter with a 2-cycle model ROM
// that returns addr[7:0]; multi-cycle corners are hand-written sequences.
module tb_sprite_rom_arbiter;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 8;
  localparam int ACT_W  = 3 + ADDR_W + 2 + DATA_W + 16;

  logic              clk;
  logic              rst;
  logic              enable;
  logic              frame_start;
  logic              req0;
  logic [ADDR_W-1:0] addr0;
  logic              req1;
  logic [ADDR_W-1:0] addr1;
  logic              gnt0;
  logic              gnt1;
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              rsp_valid0;
  logic              rsp_valid1;
  logic [DATA_W-1:0] rsp_data;
  logic [7:0]        stall0;
  logic [7:0]        stall1;

  int n_checks = 0;
  int n_errors = 0;

  sprite_rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(2)) dut (
    .clk(clk), .rst(rst), .enable(enable), .frame_start(frame_start),
    .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1),
    .gnt0(gnt0), .gnt1(gnt1), .rom_en(rom_en), .rom_addr(rom_addr),
    .rom_data(rom_data), .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
    .rsp_data(rsp_data), .stall0(stall0), .stall1(stall1)
  );

  // clock / model ROM (latency 2, data = addr[7:0])
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [ADDR_W-1:0] rom_p0;
  logic [ADDR_W-1:0] rom_p1;
  always @(posedge clk) begin
    rom_p0 <= rom_addr;
    rom_p1 <= rom_p0;
  end
  assign rom_data = rom_p1[7:0];

  logic [ACT_W-1:0] act;
  assign act = {gnt0, gnt1, rom_en, rom_addr, rsp_valid0, rsp_valid1, rsp_data, stall0, stall1};

  typedef struct {
    bit                rb;
    logic              en, fs, r0, r1;
    logic [ADDR_W-1:0] a0, a1;
    logic              g0, g1, ren;
    logic [ADDR_W-1:0] raddr;
    logic              v0, v1;
    logic [DATA_W-1:0] data;
    logic [7:0]        s0, s1;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit rb, input logic en, input logic fs, input logic r0, input logic r1,
                     input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                     input logic g0, input logic g1, input logic ren, input logic [ADDR_W-1:0] raddr,
                     input logic v0, input logic v1, input logic [DATA_W-1:0] data,
                     input logic [7:0] s0, input logic [7:0] s1);
    vec_t v;
    v.rb = rb; v.en = en; v.fs = fs; v.r0 = r0; v.r1 = r1; v.a0 = a0; v.a1 = a1;
    v.g0 = g0; v.g1 = g1; v.ren = ren; v.raddr = raddr; v.v0 = v0; v.v1 = v1;
    v.data = data; v.s0 = s0; v.s1 = s1;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset with requests pending: every output must read 0 while rst is low.
  task automatic do_reset();
    rst = 1'b0; enable = 1'b1; frame_start = 1'b0;
    req0 = 1'b1; req1 = 1'b1; addr0 = 17'h1FFFF; addr1 = 17'h0ABCD;
    @(negedge clk);
    check("reset_state", 64'(act), 64'd0);
    step();
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; frame_start = 1'b0;
    req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;

    // single request
    add(1,1,0,1,0,17'h123,0,       1,0,1,17'h123, 0,0,8'h00, 0,0);
    add(0,1,0,0,0,0,0,             0,0,0,0,       0,0,8'h00, 0,0);
    add(0,1,0,0,0,0,0,             0,0,0,0,       0,0,8'h00, 0,0);
    add(0,1,0,0,0,0,0,             0,0,0,0,       1,0,8'h23, 0,0);
    add(0,1,0,0,0,0,0,             0,0,0,0,       0,0,8'h23, 0,0);
    // continuous conflict from reset
    add(1,1,0,1,1,17'h0AA,17'h155, 1,0,1,17'h0AA, 0,0,8'h00, 0,0);
    add(0,1,0,1,1,17'h0AA,17'h155, 0,1,1,17'h155, 0,0,8'h00, 0,1);
    add(0,1,0,1,1,17'h0AA,17'h155, 1,0,1,17'h0AA, 0,0,8'h00, 1,1);
    add(0,1,0,1,1,17'h0AA,17'h155, 0,1,1,17'h155, 1,0,8'hAA, 1,2);
    add(0,1,0,1,1,17'h0AA,17'h155, 1,0,1,17'h0AA, 0,1,8'h55, 2,2);
    add(0,1,0,1,1,17'h0AA,17'h155, 0,1,1,17'h155, 1,0,8'hAA, 2,3);
    add(0,1,0,0,0,0,0,             0,0,0,0,       0,1,8'h55, 3,3);
    add(0,1,0,0,0,0,0,             0,0,0,0,       1,0,8'hAA, 3,3);
    add(0,1,0,0,0,0,0,             0,0,0,0,       0,1,8'h55, 3,3);
    add(0,1,0,0,0,0,0,             0,0,0,0,       0,0,8'h55, 3,3);
    // frame priority: last = 0, then frame_start with both requesting
    add(0,1,0,1,0,17'h001,0,       1,0,1,17'h001, 0,0,8'h55, 3,3);
    add(0,1,1,1,1,17'h001,17'h102, 1,0,1,17'h001, 0,0,8'h55, 3,3);
    add(0,1,0,0,1,0,17'h102,       0,1,1,17'h102, 0,0,8'h55, 0,0);
    add(0,1,0,0,0,0,0,             0,0,0,0,       1,0,8'h01, 0,0);
    add(0,1,0,0,0,0,0,             0,0,0,0,       1,0,8'h01, 0,0);
    add(0,1,0,0,0,0,0,             0,0,0,0,       0,1,8'h02, 0,0);
    add(0,1,0,0,0,0,0,             0,0,0,0,       0,0,8'h02, 0,0);
    // enable low while a read is in flight
    add(1,1,0,0,1,0,17'h0F0,       0,1,1,17'h0F0, 0,0,8'h00, 0,0);
    add(0,0,0,0,1,0,17'h0F0,       0,0,0,0,       0,0,8'h00, 0,0);
    add(0,0,0,0,1,0,17'h0F0,       0,0,0,0,       0,0,8'h00, 0,1);
    add(0,0,0,0,1,0,17'h0F0,       0,0,0,0,       0,1,8'hF0, 0,2);
    add(0,0,0,0,1,0,17'h0F0,       0,0,0,0,       0,0,8'hF0, 0,3);
    add(0,1,0,0,1,0,17'h0F0,       0,1,1,17'h0F0, 0,0,8'hF0, 0,4);
    add(0,1,0,0,0,0,0,             0,0,0,0,       0,0,8'hF0, 0,4);
    add(0,1,0,0,0,0,0,             0,0,0,0,       0,0,8'hF0, 0,4);
    add(0,1,0,0,0,0,0,             0,0,0,0,       0,1,8'hF0, 0,4);

    foreach (vecs[i]) begin
      logic [ACT_W-1:0] exp_v;
      if (vecs[i].rb) do_reset();
      enable = vecs[i].en; frame_start = vecs[i].fs;
      req0 = vecs[i].r0; req1 = vecs[i].r1;
      addr0 = vecs[i].a0; addr1 = vecs[i].a1;
      exp_v = {vecs[i].g0, vecs[i].g1, vecs[i].ren, vecs[i].raddr,
               vecs[i].v0, vecs[i].v1, vecs[i].data, vecs[i].s0, vecs[i].s1};
      @(negedge clk);
      check($sformatf("vec%0d", i), 64'(act), 64'(exp_v));
      step();
    end

    // saturation: req1 denied with enable low for 300 cycles
    do_reset();
    enable = 1'b0; req1 = 1'b1; addr1 = 17'h00077;
    for (int i = 0; i < 300; i++) begin
      logic [7:0] e;
      e = (i > 255) ? 8'd255 : 8'(i);
      @(negedge clk);
      check($sformatf("sat%0d", i), {55'd0, gnt1, stall1}, {55'd0, 1'b0, e});
      step();
    end
    frame_start = 1'b1;
    @(negedge clk);
    check("sat_hold", 64'(stall1), 64'd255);
    step();
    frame_start = 1'b0;
    @(negedge clk);
    check("sat_clear", 64'(stall1), 64'd0);
    step();
    @(negedge clk);
    check("sat_restart", 64'(stall1), 64'd1);
    step();

    // reset mid-flight
    do_reset();
    enable = 1'b1; req0 = 1'b1; addr0 = 17'h044;
    @(negedge clk);
    check("rmf_grant", {gnt0, gnt1, rom_en, rom_addr}, {1'b1, 1'b0, 1'b1, 17'h044});
    step();
    rst = 1'b0; req0 = 1'b0; addr0 = '0; req1 = 1'b1; addr1 = 17'h033;
    @(negedge clk);
    check("rmf_in_reset", 64'(act), 64'd0);
    step();
    rst = 1'b1; req1 = 1'b0; addr1 = '0;
    @(negedge clk);
    check("rmf_c2_rsp", {rsp_valid0, rsp_valid1}, 2'b00);
    step();
    @(negedge clk);
    check("rmf_c3_rsp", {rsp_valid0, rsp_valid1}, 2'b00);
    step();
    req0 = 1'b1; addr0 = 17'h011; req1 = 1'b1; addr1 = 17'h022;
    @(negedge clk);
    check("rmf_first_conflict", {gnt0, gnt1, rom_addr, rsp_valid0, rsp_valid1},
          {1'b1, 1'b0, 17'h011, 1'b0, 1'b0});
    step();
    req0 = 1'b0; req1 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
